// File: rtl/prefetch_perf_tracker_pkg.sv
// Shared types for the dcache prefetch performance tracker.
// Line fields are sized for the largest supported table; narrower indices are zero-extended.
package prefetch_perf_tracker_pkg;

    localparam int PERF_CTR_BITS = 44;
    localparam int EVT_LINE_BITS = 16;

    typedef logic [EVT_LINE_BITS-1:0] evt_line_t;

    typedef struct packed {
        logic      pf_req;
        logic      fill_valid;
        evt_line_t fill_line;
        logic      fill_used;
        logic      hit_valid;
        evt_line_t hit_line;
        logic      evict_valid;
        evt_line_t evict_line;
        logic      late;
        logic      flush;
    } prefetch_evt_t;

    function automatic logic line_match(input logic valid, input evt_line_t line, input int unsigned idx);
        return valid && (line == evt_line_t'(idx));
    endfunction

endpackage

// File: rtl/prefetch_line_table.sv
// Per-line "prefetched, not yet demanded" bit table with same-cycle priority resolution.
// The evict index reads the pre-update bit; the table is written at the end of the same edge.
module prefetch_line_table
    import prefetch_perf_tracker_pkg::*;
#(
    parameter int NUM_LINES = 256
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      fill_valid,
    input  evt_line_t fill_line,
    input  logic      fill_used,
    input  logic      hit_valid,
    input  evt_line_t hit_line,
    input  logic      evict_valid,
    input  evt_line_t evict_line,
    input  logic      flush,
    output logic      evict_old_bit
);

    logic [NUM_LINES-1:0] pf_bits_r;
    logic [NUM_LINES-1:0] pf_bits_next_s;
    logic [NUM_LINES-1:0] fill_sel_s;
    logic [NUM_LINES-1:0] hit_sel_s;
    logic [NUM_LINES-1:0] evict_sel_s;

    // Decode the three independent line indices into one-hot selects.
    always_comb begin
        fill_sel_s  = {NUM_LINES{1'b0}};
        hit_sel_s   = {NUM_LINES{1'b0}};
        evict_sel_s = {NUM_LINES{1'b0}};
        for (int i = 0; i < NUM_LINES; i++) begin
            fill_sel_s[i]  = line_match(fill_valid, fill_line, i);
            hit_sel_s[i]   = line_match(hit_valid, hit_line, i);
            evict_sel_s[i] = line_match(evict_valid, evict_line, i);
        end
    end

    // Next bit per line: an unused fill sets it and wins over hit, evict and flush.
    always_comb begin
        pf_bits_next_s = pf_bits_r;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (fill_sel_s[i] && !fill_used) begin
                pf_bits_next_s[i] = 1'b1;
            end else if (fill_sel_s[i] || hit_sel_s[i] || evict_sel_s[i] || flush) begin
                pf_bits_next_s[i] = 1'b0;
            end else begin
                pf_bits_next_s[i] = pf_bits_r[i];
            end
        end
    end

    // Old bit of the evicted line, before this cycle's update.
    always_comb begin
        evict_old_bit = |(pf_bits_r & evict_sel_s);
    end

    // Bit table storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            pf_bits_r <= {NUM_LINES{1'b0}};
        end else begin
            pf_bits_r <= pf_bits_next_s;
        end
    end

endmodule

// File: rtl/prefetch_perf_tracker.sv
// Dcache prefetch performance counters: requests, prefetched blocks, unused blocks, late prefetches.
// Two stages: S1 registers the event pulses, S2 updates the line table and counters.
module prefetch_perf_tracker #(
    parameter int NUM_LINES     = 256,
    parameter int LINE_SEL_BITS = $clog2(NUM_LINES),
    parameter int PERF_CTR_BITS = prefetch_perf_tracker_pkg::PERF_CTR_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pf_req_fire,
    input  logic                     pf_fill_valid,
    input  logic [LINE_SEL_BITS-1:0] pf_fill_line,
    input  logic                     pf_fill_used,
    input  logic                     dmd_hit_valid,
    input  logic [LINE_SEL_BITS-1:0] dmd_hit_line,
    input  logic                     evict_valid,
    input  logic [LINE_SEL_BITS-1:0] evict_line,
    input  logic                     late_pf_valid,
    input  logic                     flush,
    output logic [PERF_CTR_BITS-1:0] prefetch_requests,
    output logic [PERF_CTR_BITS-1:0] prefetched_blocks,
    output logic [PERF_CTR_BITS-1:0] unused_prefetched_blocks,
    output logic [PERF_CTR_BITS-1:0] late_prefetches
);

    import prefetch_perf_tracker_pkg::prefetch_evt_t;
    import prefetch_perf_tracker_pkg::EVT_LINE_BITS;

    localparam int EVT_BITS = $bits(prefetch_evt_t);

    prefetch_evt_t            evt_s;
    prefetch_evt_t            evt_r;
    logic                     evict_old_bit_s;
    logic                     unused_inc_s;
    logic [PERF_CTR_BITS-1:0] req_cnt_r;
    logic [PERF_CTR_BITS-1:0] blk_cnt_r;
    logic [PERF_CTR_BITS-1:0] unused_cnt_r;
    logic [PERF_CTR_BITS-1:0] late_cnt_r;

    // Pack the raw event pulses into one S1 record.
    always_comb begin
        evt_s             = prefetch_evt_t'({EVT_BITS{1'b0}});
        evt_s.pf_req      = pf_req_fire;
        evt_s.fill_valid  = pf_fill_valid;
        evt_s.fill_line   = EVT_LINE_BITS'(pf_fill_line);
        evt_s.fill_used   = pf_fill_used;
        evt_s.hit_valid   = dmd_hit_valid;
        evt_s.hit_line    = EVT_LINE_BITS'(dmd_hit_line);
        evt_s.evict_valid = evict_valid;
        evt_s.evict_line  = EVT_LINE_BITS'(evict_line);
        evt_s.late        = late_pf_valid;
        evt_s.flush       = flush;
    end

    // S1 event register; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_r <= prefetch_evt_t'({EVT_BITS{1'b0}});
        end else begin
            evt_r <= evt_s;
        end
    end

    prefetch_line_table #(
        .NUM_LINES(NUM_LINES)
    ) u_table (
        .clk          (clk),
        .reset        (reset),
        .fill_valid   (evt_r.fill_valid),
        .fill_line    (evt_r.fill_line),
        .fill_used    (evt_r.fill_used),
        .hit_valid    (evt_r.hit_valid),
        .hit_line     (evt_r.hit_line),
        .evict_valid  (evt_r.evict_valid),
        .evict_line   (evt_r.evict_line),
        .flush        (evt_r.flush),
        .evict_old_bit(evict_old_bit_s)
    );

    // A same-line hit is ordered before the eviction, so that line was used.
    always_comb begin
        if (evt_r.hit_valid && (evt_r.hit_line == evt_r.evict_line)) begin
            unused_inc_s = 1'b0;
        end else begin
            unused_inc_s = evt_r.evict_valid & evict_old_bit_s;
        end
    end

    // S2 counters, wrapping modulo 2^PERF_CTR_BITS.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_cnt_r    <= {PERF_CTR_BITS{1'b0}};
            blk_cnt_r    <= {PERF_CTR_BITS{1'b0}};
            unused_cnt_r <= {PERF_CTR_BITS{1'b0}};
            late_cnt_r   <= {PERF_CTR_BITS{1'b0}};
        end else begin
            req_cnt_r    <= req_cnt_r    + {{(PERF_CTR_BITS-1){1'b0}}, evt_r.pf_req};
            blk_cnt_r    <= blk_cnt_r    + {{(PERF_CTR_BITS-1){1'b0}}, evt_r.fill_valid};
            unused_cnt_r <= unused_cnt_r + {{(PERF_CTR_BITS-1){1'b0}}, unused_inc_s};
            late_cnt_r   <= late_cnt_r   + {{(PERF_CTR_BITS-1){1'b0}}, evt_r.late};
        end
    end

    assign prefetch_requests        = req_cnt_r;
    assign prefetched_blocks        = blk_cnt_r;
    assign unused_prefetched_blocks = unused_cnt_r;
    assign late_prefetches          = late_cnt_r;

endmodule

// File: tb/tb_prefetch_perf_tracker.sv
// Self-checking bench for prefetch_perf_tracker: directed scenarios plus randomized
// traffic compared against an event-ordered reference model of the line table and counters.
module tb_prefetch_perf_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       pf_req_fire, pf_fill_valid, pf_fill_used, dmd_hit_valid;
    logic       evict_valid, late_pf_valid, flush;
    logic [7:0] pf_fill_line, dmd_hit_line, evict_line;

    logic [43:0] prefetch_requests, prefetched_blocks, unused_prefetched_blocks, late_prefetches;
    logic [3:0]  w_req, w_blk, w_unused, w_late;

    int errors = 0;
    int checks = 0;

    bit          m_bits[256];
    longint unsigned m_req, m_blk, m_unused, m_late;

    always #5 clk = ~clk;

    prefetch_perf_tracker dut (
        .clk(clk), .reset(reset), .pf_req_fire(pf_req_fire),
        .pf_fill_valid(pf_fill_valid), .pf_fill_line(pf_fill_line), .pf_fill_used(pf_fill_used),
        .dmd_hit_valid(dmd_hit_valid), .dmd_hit_line(dmd_hit_line),
        .evict_valid(evict_valid), .evict_line(evict_line),
        .late_pf_valid(late_pf_valid), .flush(flush),
        .prefetch_requests(prefetch_requests), .prefetched_blocks(prefetched_blocks),
        .unused_prefetched_blocks(unused_prefetched_blocks), .late_prefetches(late_prefetches)
    );

    prefetch_perf_tracker #(.PERF_CTR_BITS(4)) dut4 (
        .clk(clk), .reset(reset), .pf_req_fire(pf_req_fire),
        .pf_fill_valid(pf_fill_valid), .pf_fill_line(pf_fill_line), .pf_fill_used(pf_fill_used),
        .dmd_hit_valid(dmd_hit_valid), .dmd_hit_line(dmd_hit_line),
        .evict_valid(evict_valid), .evict_line(evict_line),
        .late_pf_valid(late_pf_valid), .flush(flush),
        .prefetch_requests(w_req), .prefetched_blocks(w_blk),
        .unused_prefetched_blocks(w_unused), .late_prefetches(w_late)
    );

    function automatic logic [255:0] model_bits();
        logic [255:0] v;
        for (int i = 0; i < 256; i++) v[i] = m_bits[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_bits[i] = 1'b0;
        m_req = 0; m_blk = 0; m_unused = 0; m_late = 0;
    endtask

    task automatic clear_inputs();
        pf_req_fire = 1'b0; pf_fill_valid = 1'b0; pf_fill_used = 1'b0; dmd_hit_valid = 1'b0;
        evict_valid = 1'b0; late_pf_valid = 1'b0; flush = 1'b0;
        pf_fill_line = 8'd0; dmd_hit_line = 8'd0; evict_line = 8'd0;
    endtask

    // Drive one cycle of events and apply them to the model in causal order:
    // hit, then evict, then flush, then fill.
    task automatic step(input bit req, input bit fv, input int fl, input bit fu,
                        input bit hv, input int hl, input bit ev, input int el,
                        input bit lt, input bit fsh);
        pf_req_fire = req; pf_fill_valid = fv; pf_fill_line = fl[7:0]; pf_fill_used = fu;
        dmd_hit_valid = hv; dmd_hit_line = hl[7:0]; evict_valid = ev; evict_line = el[7:0];
        late_pf_valid = lt; flush = fsh;
        m_req += req; m_blk += fv; m_late += lt;
        if (hv) m_bits[hl[7:0]] = 1'b0;
        if (ev) begin
            if (m_bits[el[7:0]]) m_unused++;
            m_bits[el[7:0]] = 1'b0;
        end
        if (fsh) for (int i = 0; i < 256; i++) m_bits[i] = 1'b0;
        if (fv) m_bits[fl[7:0]] = !fu;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        logic [255:0] b;
        do_reset(2);
        b = dut.u_table.pf_bits_r;
        checks++;
        if ({prefetch_requests, prefetched_blocks, unused_prefetched_blocks, late_prefetches} !== 176'd0) begin
            errors++;
            $display("FAIL reset_counters: got %h %h %h %h want all 0", prefetch_requests,
                     prefetched_blocks, unused_prefetched_blocks, late_prefetches);
        end
        checks++;
        if (b !== 256'd0) begin errors++; $display("FAIL reset_bits: got %h want 0", b); end
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
            checks++;
            if (prefetch_requests !== 44'(k - 1)) begin
                errors++; $display("FAIL req_latency_early: got %0d want %0d", prefetch_requests, k - 1);
            end
            idle(1);
            checks++;
            if (prefetch_requests !== 44'(k)) begin
                errors++; $display("FAIL req_latency: got %0d want %0d", prefetch_requests, k);
            end
        end
    endtask

    task automatic test_unused_eviction();
        do_reset(1);
        step(1'b0, 1'b1, 5, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        idle(9);
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 5, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (prefetched_blocks !== 44'd1) begin
            errors++; $display("FAIL unused_blocks: got %0d want 1", prefetched_blocks);
        end
        checks++;
        if (unused_prefetched_blocks !== 44'd1) begin
            errors++; $display("FAIL unused_count: got %0d want 1", unused_prefetched_blocks);
        end
        step(1'b0, 1'b1, 5, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        idle(4);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, 5, 1'b0, 0, 1'b0, 1'b0);
        idle(4);
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 5, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (unused_prefetched_blocks !== 44'd1 || prefetched_blocks !== 44'd2) begin
            errors++; $display("FAIL used_then_evict: got unused=%0d blocks=%0d want 1 2",
                               unused_prefetched_blocks, prefetched_blocks);
        end
    endtask

    task automatic test_same_cycle();
        logic [255:0] b;
        do_reset(1);
        step(1'b0, 1'b1, 7, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1, 7, 1'b1, 7, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (unused_prefetched_blocks !== 44'd0) begin
            errors++; $display("FAIL hit_evict_same: got %0d want 0", unused_prefetched_blocks);
        end
        step(1'b0, 1'b1, 7, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 7, 1'b0, 1'b0, 0, 1'b1, 7, 1'b0, 1'b0);
        idle(1);
        b = dut.u_table.pf_bits_r;
        checks++;
        if (unused_prefetched_blocks !== 44'd1 || b[7] !== 1'b1) begin
            errors++; $display("FAIL evict_fill_same: got unused=%0d bit7=%b want 1 1",
                               unused_prefetched_blocks, b[7]);
        end
        step(1'b0, 1'b1, 8, 1'b0, 1'b1, 8, 1'b0, 0, 1'b0, 1'b0);
        idle(1);
        b = dut.u_table.pf_bits_r;
        checks++;
        if (b[8] !== 1'b1) begin errors++; $display("FAIL hit_fill_same: got bit8=%b want 1", b[8]); end
    endtask

    task automatic test_late_prefetch();
        do_reset(1);
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 9, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, 9, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (late_prefetches !== 44'd1 || prefetched_blocks !== 44'd1 || unused_prefetched_blocks !== 44'd0) begin
            errors++; $display("FAIL late_prefetch: got late=%0d blocks=%0d unused=%0d want 1 1 0",
                               late_prefetches, prefetched_blocks, unused_prefetched_blocks);
        end
    endtask

    task automatic test_flush();
        logic [255:0] b;
        do_reset(1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, i, 1'b0, 1'b0);
        idle(1);
        b = dut.u_table.pf_bits_r;
        checks++;
        if (unused_prefetched_blocks !== 44'd0 || prefetched_blocks !== 44'd4 || b !== 256'd0) begin
            errors++; $display("FAIL flush_clear: got unused=%0d blocks=%0d bits=%h want 0 4 0",
                               unused_prefetched_blocks, prefetched_blocks, b);
        end
        step(1'b0, 1'b1, 4, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        idle(1);
        b = dut.u_table.pf_bits_r;
        checks++;
        if (b !== 256'h10) begin errors++; $display("FAIL flush_fill_same: got %h want 10", b); end
    endtask

    task automatic test_wrap();
        do_reset(1);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        idle(1);
        checks++;
        if (w_req !== 4'd1) begin errors++; $display("FAIL wrap4: got %0d want 1", w_req); end
        checks++;
        if (prefetch_requests !== 44'd17) begin
            errors++; $display("FAIL wrap44: got %0d want 17", prefetch_requests);
        end
    endtask

    task automatic test_random();
        logic [255:0] b;
        do_reset(1);
        for (int r = 0; r < 8; r++) begin
            for (int s = 0; s < 40; s++) begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), $urandom_range(0, 7),
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), $urandom_range(0, 7),
                     1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 31) == 0));
            end
            idle(1);
            b = dut.u_table.pf_bits_r;
            checks++;
            if (prefetch_requests !== m_req[43:0] || prefetched_blocks !== m_blk[43:0] ||
                unused_prefetched_blocks !== m_unused[43:0] || late_prefetches !== m_late[43:0]) begin
                errors++;
                $display("FAIL random_counters r%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d", r,
                         prefetch_requests, prefetched_blocks, unused_prefetched_blocks, late_prefetches,
                         m_req, m_blk, m_unused, m_late);
            end
            checks++;
            if (b !== model_bits()) begin
                errors++; $display("FAIL random_bits r%0d: got %h want %h", r, b, model_bits());
            end
            checks++;
            if ({w_req, w_blk, w_unused, w_late} !== {m_req[3:0], m_blk[3:0], m_unused[3:0], m_late[3:0]}) begin
                errors++; $display("FAIL random_narrow r%0d: got %h want %h", r,
                                   {w_req, w_blk, w_unused, w_late},
                                   {m_req[3:0], m_blk[3:0], m_unused[3:0], m_late[3:0]});
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [255:0] b;
        do_reset(1);
        step(1'b1, 1'b1, 3, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        idle(2);
        checks++;
        if (prefetched_blocks !== 44'd1) begin
            errors++; $display("FAIL midreset_pre: got %0d want 1", prefetched_blocks);
        end
        reset = 1'b1; evict_valid = 1'b1; evict_line = 8'd3;
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        model_clear();
        idle(3);
        b = dut.u_table.pf_bits_r;
        checks++;
        if ({prefetch_requests, prefetched_blocks, unused_prefetched_blocks, late_prefetches} !== 176'd0 ||
            b !== 256'd0) begin
            errors++; $display("FAIL midreset_post: got %0d %0d %0d %0d bits=%h want all 0",
                               prefetch_requests, prefetched_blocks, unused_prefetched_blocks,
                               late_prefetches, b);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        model_clear();
        test_reset();
        test_unused_eviction();
        test_same_cycle();
        test_late_prefetch();
        test_flush();
        test_wrap();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prefetch_perf_tracker.md
Name: prefetch_perf_tracker

Overview:
Per-bank event collector that produces the four dcache prefetch performance counters: prefetch requests, prefetched blocks, unused prefetched blocks and late prefetches. It sits between the dcache bank/prefetcher event pulses and the perf-memsys counter bundle, and drives those four fields directly. It keeps a per-line "prefetched, not yet demanded" bit table so that it can detect prefetched lines that are evicted without ever being used.

Parameters:
NUM_LINES, 256, cache lines tracked; power of two, at least 2
LINE_SEL_BITS, $clog2(NUM_LINES), line index width (derived)
PERF_CTR_BITS, 44, counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pf_req_fire  in  1  prefetch request accepted by the memory request arbiter this cycle
pf_fill_valid  in  1  prefetch fill written into a line
pf_fill_line  in  LINE_SEL_BITS  line index of the fill
pf_fill_used  in  1  the fill also satisfies a merged demand miss (late prefetch fill)
dmd_hit_valid  in  1  demand access hit
dmd_hit_line  in  LINE_SEL_BITS  line index of the hit
evict_valid  in  1  valid line evicted or replaced
evict_line  in  LINE_SEL_BITS  line index of the eviction
late_pf_valid  in  1  demand miss merged into an in-flight prefetch MSHR entry
flush  in  1  cache flush; clear the table
prefetch_requests  out  PERF_CTR_BITS  counter
prefetched_blocks  out  PERF_CTR_BITS  counter
unused_prefetched_blocks  out  PERF_CTR_BITS  counter
late_prefetches  out  PERF_CTR_BITS  counter

Behaviour:
- Two-stage pipeline.
  - S1: all inputs registered; valids are cleared on reset.
  - S2: table read and update, counter increment.
  - An event sampled at edge N is visible on the outputs after edge N+1. Fixed latency, no stalls, no backpressure.
- Bit table: NUM_LINES flops, pf_bit[i].
  - Read combinationally in S2 and written at the end of the same edge.
  - Back-to-back events on the same line therefore see the updated value; no forwarding is needed.
- Per-cycle S2 update for each line L (all three index ports are evaluated independently):
  - new = 1 if (fill to L and !pf_fill_used)
  - else 0 if (hit to L or evict to L or fill to L with pf_fill_used)
  - else old.
- Counter increments per cycle (each at most +1):
  - prefetch_requests += pf_req_fire
  - prefetched_blocks += pf_fill_valid, regardless of pf_fill_used
  - unused_prefetched_blocks += evict_valid & pf_bit[evict_line] & !(dmd_hit_valid & dmd_hit_line==evict_line)
  - late_prefetches += late_pf_valid
- Simultaneous events on the same line:
  - Hit and evict: the hit is ordered first, so the line is not counted as unused.
  - Evict and fill: the old bit decides the unused count; the final bit follows the fill.
  - Hit and fill: the fill wins, so the bit is set when pf_fill_used=0.
- Counters wrap modulo 2^PERF_CTR_BITS; there is no saturation.
- flush:
  - Registered in S1; in S2 it clears all pf_bits. Bits still set are not counted as unused.
  - Counters are not cleared.
  - Any fill arriving in the same S2 cycle as the flush is applied after the clear, so its bit ends set.
- reset:
  - Clears S1 registers, all pf_bits and all four counters to 0 on the next edge, including mid-operation.
  - Events in flight in S1 are dropped.
  - All outputs read 0 from the edge after reset is asserted until the first post-reset event.
- Index inputs are ignored when their valid is low.

Decomposition:
- Shared package (VX_gpu_pkg or equivalent):
  - PERF_CTR_BITS
  - a prefetch_evt_t struct (pf_req, fill valid/line/used, hit valid/line, evict valid/line, late, flush), parameterised via LINE_SEL_BITS
- One natural sub-module: prefetch_line_table, holding the NUM_LINES bit array and the update/priority logic and returning the old bit for the evict index.
- The counters stay in the top module.

Test Plan:
- Reset:
  - Assert reset 2 cycles.
  - Required: all four outputs 0 and all pf_bits 0.
  - Then 3 pf_req_fire pulses; required: prefetch_requests=3, each increment 2 edges after its input.
- Unused eviction:
  - Fill line 5 (used=0); evict line 5 ten cycles later.
  - Required: prefetched_blocks=1, unused_prefetched_blocks=1.
  - Repeat with a hit on line 5 in between; required: unused stays 1.
- Same-cycle hit and evict:
  - Fill line 7; then hit line 7 and evict line 7 in the same cycle.
  - Required: unused_prefetched_blocks unchanged.
  - Same-cycle evict of line 7 plus a fill to line 7; required: unused +1 and pf_bit[7]=1 afterwards.
- Late prefetch:
  - late_pf_valid, then fill line 9 with pf_fill_used=1, then evict line 9.
  - Required: late_prefetches=1, prefetched_blocks=1, unused=0.
- Flush and wrap:
  - Fill lines 0..3, flush, evict lines 0..3; required: unused=0.
  - Separately, with PERF_CTR_BITS=4, issue 17 pf_req_fire pulses; required: prefetch_requests=1.
- Reset mid-stream:
  - Assert reset in the same cycle as an evict of a set line.
  - Required: all counters 0 afterwards and no increment leaking from the dropped event.
